imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage. It takes a full 32-bit instruction word, a 3-bit format select and the instruction PC. It produces the XLEN-wide sign- or zero-extended immediate, the PC-relative target `pc + imm` and an illegal-format flag. It sits between fetch/decode and execute, with a valid/ready handshake and a 2-entry skid buffer, so both ready and data paths are registered.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: synchronous pipeline flush.
- `in_valid` in, 1: input beat valid.
- `in_ready` out, 1: block can accept a beat.
- `instr` in, 32: raw instruction word.
- `immsrc` in, 3: format select (see Operation).
- `pc` in, XLEN: PC of the instruction.
- `out_valid` out, 1: output beat valid.
- `out_ready` in, 1: consumer accepts the beat.
- `immext` out, XLEN: extended immediate.
- `pc_target` out, XLEN: `pc + immext`, modulo 2^XLEN.
- `illegal` out, 1: `immsrc` was the reserved code.

## Operation
- Formats. `s` = `instr[31]` replicated to XLEN.
  - 000 I: `{s, instr[31:20]}`.
  - 001 S: `{s, instr[31:25], instr[11:7]}`.
  - 010 B: `{s, instr[7], instr[30:25], instr[11:8], 0}`.
  - 011 J: `{s, instr[19:12], instr[20], instr[30:21], 0}`.
  - 100 U: `{s, instr[31:12], 12'b0}`. For XLEN=64, sign-extend from bit 31.
  - 101 Z (CSR uimm): zero-extended `instr[19:15]`.
  - 110 SH (shift amount): zero-extended `instr[24:20]` for XLEN=32; `instr[25:20]` for XLEN=64.
  - 111: reserved. `immext` = 0, `illegal` = 1, `pc_target` = `pc`.
- `pc_target` is computed for every format. It wraps silently on overflow; no carry out.
- Buffer: 2 entries, each holding {immext, pc_target, illegal}. Occupancy state is EMPTY, ONE or TWO.
  - `in_ready` = (state != TWO), driven from a register.
  - Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
  - EMPTY: push → ONE.
  - ONE: push only → TWO; pop only → EMPTY; push and pop together → ONE (new beat queued behind the popped one).
  - TWO: pop → ONE. No push is possible because `in_ready` = 0.
- Ordering is strict FIFO.
- `out_valid` = (state != EMPTY). Output data is the head entry and is held stable while `out_valid && !out_ready`.
- `flush` has priority over push and pop:
  - next state is EMPTY;
  - a beat presented in the flush cycle is dropped;
  - a pop in the flush cycle still completes.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, `out_valid` 0, `in_ready` 1;
  - `immext`, `pc_target` and `illegal` all 0;
  - buffered beats are discarded.

## Timing
- Latency: a beat accepted at edge N is on the output after edge N, i.e. visible in cycle N+1 when the buffer was empty.
- Throughput: one beat per cycle while `out_ready` = 1.
- Stall recovery: after `out_ready` rises with the buffer in TWO, `in_ready` returns to 1 one cycle later.
- No combinational path from `out_ready` to `in_ready`. No combinational path from `instr`/`pc` to any output.
- Flush takes effect at the next edge.

## Structure
- Shared package `imm_pkg`:
  - `immsrc` codes as named constants IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_RSV;
  - entry struct {immext, pc_target, illegal}.
- Sub-module `imm_decode`: purely combinational, parametrised by XLEN. Maps (`instr`, `immsrc`) to (`immext`, `illegal`).
- Top level holds the adder, the 2-entry buffer and the state register.

## Test plan
- I-type: `instr` 0xFFF00093, `immsrc` 000, `pc` 0x100 → `immext` 0xFFFFFFFF, `pc_target` 0x000000FF, `illegal` 0, one cycle later.
- B and J:
  - `instr` 0xFE000EE3, `immsrc` 010, `pc` 0x100 → `immext` 0xFFFFFFFC, `pc_target` 0x000000FC.
  - `instr` 0x001000EF, `immsrc` 011, `pc` 0x1000 → `immext` 0x00000800, `pc_target` 0x00001800.
- U/Z/reserved and wrap:
  - `instr` 0x123450B7, `immsrc` 100 → `immext` 0x12345000.
  - `immsrc` 101 with `instr[19:15]` = 0x1F → `immext` 0x1F.
  - `immsrc` 111 → `immext` 0, `illegal` 1.
  - `pc` 0xFFFFFFFC with I-imm 8 → `pc_target` 0x00000004.
- Backpressure: hold `out_ready` = 0 and present 3 beats.
  - `in_ready` drops after 2 beats are accepted; the third beat is held.
  - Raise `out_ready`: all 3 beats emerge in order, and `in_ready` returns to 1 one cycle after the first pop.
- Flush and reset: fill to TWO, then assert `flush` together with a new `in_valid` beat.
  - Next cycle: `out_valid` 0, `in_ready` 1, and the new beat never appears.
  - Repeat with `rst_n` pulsed low mid-cycle instead: all outputs go to reset values immediately.
- XLEN=64: `instr` 0x800000B7 (U) → `immext` 0xFFFFFFFF80000000.
  - SH with `instr[25:20]` = 0x3F → `immext` 0x3F.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// format-select codes, buffer occupancy encoding and the buffered entry layout.
package imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    // Entries are sized for the widest legal XLEN; narrower builds use the low bits.
    localparam int IMM_XLEN_MAX = 64;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

    typedef struct packed {
        logic [IMM_XLEN_MAX-1:0] immext;
        logic [IMM_XLEN_MAX-1:0] pc_target;
        logic                    illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: maps an instruction word and a format
// select to the XLEN-wide extended immediate plus a reserved-format flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    // Every signed format is first assembled as a 32-bit value, then widened from bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        zext6 = {{(XLEN-6){1'b0}}, v};
    endfunction

    logic [5:0] shamt_s;

    // Shift amounts are 6 bits wide only on 64-bit datapaths.
    always_comb begin
        shamt_s = {1'b0, instr[24:20]};
        if (XLEN == 64) begin
            shamt_s = instr[25:20];
        end else begin
            shamt_s = {1'b0, instr[24:20]};
        end
    end

    // Format select to immediate mapping.
    always_comb begin
        immext  = {XLEN{1'b0}};
        illegal = 1'b0;
        case (immsrc)
            IMM_I:   immext = sext32({{20{instr[31]}}, instr[31:20]});
            IMM_S:   immext = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            IMM_B:   immext = sext32({{20{instr[31]}}, instr[7], instr[30:25],
                                      instr[11:8], 1'b0});
            IMM_J:   immext = sext32({{12{instr[31]}}, instr[19:12], instr[20],
                                      instr[30:21], 1'b0});
            IMM_U:   immext = sext32({instr[31:12], 12'h000});
            IMM_Z:   immext = zext6({1'b0, instr[19:15]});
            IMM_SH:  immext = zext6(shamt_s);
            IMM_RSV: begin
                immext  = {XLEN{1'b0}};
                illegal = 1'b1;
            end
            default: begin
                immext  = {XLEN{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the immediate, forms pc + imm and
// queues results in a 2-entry skid buffer so both ready and data are registered.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immext,
    output logic [XLEN-1:0] pc_target,
    output logic            illegal
);

    logic [XLEN-1:0] dec_imm_s;
    logic            dec_ill_s;
    logic [XLEN-1:0] sum_s;
    imm_entry_t      new_s;
    imm_entry_t      head_r;
    imm_entry_t      tail_r;
    buf_state_t      state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            push_s;
    logic            pop_s;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .immsrc  (immsrc),
        .immext  (dec_imm_s),
        .illegal (dec_ill_s)
    );

    // The reserved format decodes to zero, so the same adder yields pc_target = pc.
    assign sum_s = pc + dec_imm_s;

    // Pack the incoming beat into a buffer entry.
    always_comb begin
        new_s           = '0;
        new_s.immext    = IMM_XLEN_MAX'(dec_imm_s);
        new_s.pc_target = IMM_XLEN_MAX'(sum_s);
        new_s.illegal   = dec_ill_s;
    end

    assign push_s = in_valid && in_ready_r;
    assign pop_s  = out_valid_r && out_ready;

    // Occupancy FSM with registered handshakes; head_r always drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= BUF_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
            tail_r      <= '0;
        end else if (flush) begin
            state_r     <= BUF_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (push_s) begin
                        head_r      <= new_s;
                        state_r     <= BUF_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (push_s && pop_s) begin
                        head_r <= new_s;
                    end else if (push_s) begin
                        tail_r     <= new_s;
                        state_r    <= BUF_TWO;
                        in_ready_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= BUF_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (pop_s) begin
                        head_r     <= tail_r;
                        state_r    <= BUF_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= BUF_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign immext    = head_r.immext[XLEN-1:0];
    assign pc_target = head_r.pc_target[XLEN-1:0];
    assign illegal   = head_r.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vectors, backpressure/flush/reset scenarios
// and a randomized phase against a queue-based reference model, for XLEN 32 and 64.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr     = 32'h0;
    logic [2:0]  immsrc    = 3'b000;
    logic [31:0] pc32      = 32'h0;
    logic [63:0] pc64      = 64'h0;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] immext32, tgt32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] immext64, tgt64;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .pc(pc32), .out_valid(out_valid32),
        .out_ready(out_ready), .immext(immext32), .pc_target(tgt32), .illegal(illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .pc(pc64), .out_valid(out_valid64),
        .out_ready(out_ready), .immext(immext64), .pc_target(tgt64), .illegal(illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Take the low 'bits' of f as a two's-complement number, return it as 64-bit.
    function automatic longint unsigned sx(input longint unsigned f, input int bits);
        longint unsigned m;
        longint unsigned v;
        m = (64'd1 << bits) - 64'd1;
        v = f & m;
        if (((v >> (bits - 1)) & 64'd1) != 64'd0) return v - (64'd1 << bits);
        return v;
    endfunction

    function automatic exp_t ref_beat(input logic [31:0] ins, input logic [2:0] src,
                                      input logic [63:0] pcv, input int xlen);
        longint unsigned mask;
        longint unsigned w;
        longint unsigned v;
        exp_t r;
        w     = 64'(ins);
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r.ill = 1'b0;
        case (src)
            3'd0: v = sx(w >> 20, 12);
            3'd1: v = sx(((w >> 25) << 5) + ((w >> 7) & 64'd31), 12);
            3'd2: v = sx((((w >> 31) & 64'd1) << 12) + (((w >> 7) & 64'd1) << 11)
                         + (((w >> 25) & 64'd63) << 5) + (((w >> 8) & 64'd15) << 1), 13);
            3'd3: v = sx((((w >> 31) & 64'd1) << 20) + (((w >> 12) & 64'd255) << 12)
                         + (((w >> 20) & 64'd1) << 11) + (((w >> 21) & 64'd1023) << 1), 21);
            3'd4: v = sx(w & 64'hFFFF_F000, 32);
            3'd5: v = (w >> 15) & 64'd31;
            3'd6: v = (xlen == 64) ? ((w >> 20) & 64'd63) : ((w >> 20) & 64'd31);
            default: begin
                v     = 64'd0;
                r.ill = 1'b1;
            end
        endcase
        r.imm = v & mask;
        r.tgt = (pcv + r.imm) & mask;
        return r;
    endfunction

    // Present one beat from an empty buffer; on return it is visible on the outputs.
    task automatic send1(input logic [31:0] i, input logic [2:0] s, input logic [31:0] p);
        @(negedge clk);
        instr = i; immsrc = s; pc32 = p; pc64 = {32'h0, p};
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_two();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; immsrc = IMM_I;
        instr = 32'h00A00093; pc32 = 32'h300; pc64 = 64'h300;
        @(negedge clk);
        instr = 32'h00B00093;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_in_ready", in_ready32, 64'd0);
        chk("fill_out_valid", out_valid32, 64'd1);
    endtask

    task automatic check_models();
        chk("rnd_in_ready32", in_ready32, 64'(q32.size() < 2));
        chk("rnd_out_valid32", out_valid32, 64'(q32.size() != 0));
        if (q32.size() != 0) begin
            chk("rnd_immext32", immext32, q32[0].imm);
            chk("rnd_target32", tgt32, q32[0].tgt);
            chk("rnd_illegal32", illegal32, q32[0].ill);
        end
        chk("rnd_in_ready64", in_ready64, 64'(q64.size() < 2));
        chk("rnd_out_valid64", out_valid64, 64'(q64.size() != 0));
        if (q64.size() != 0) begin
            chk("rnd_immext64", immext64, q64[0].imm);
            chk("rnd_target64", tgt64, q64[0].tgt);
            chk("rnd_illegal64", illegal64, q64[0].ill);
        end
    endtask

    initial begin
        // Reset state, held across the first rising edge.
        @(negedge clk);
        chk("rst_in_ready", in_ready32, 64'd1);
        chk("rst_out_valid", out_valid32, 64'd0);
        chk("rst_immext", immext32, 64'd0);
        chk("rst_target", tgt32, 64'd0);
        chk("rst_illegal", illegal32, 64'd0);
        chk("rst_out_valid64", out_valid64, 64'd0);
        rst_n = 1'b1;

        // Directed format vectors.
        send1(32'hFFF00093, IMM_I, 32'h100);
        chk("i_valid", out_valid32, 64'd1);
        chk("i_imm", immext32, 64'hFFFF_FFFF);
        chk("i_tgt", tgt32, 64'h0000_00FF);
        chk("i_ill", illegal32, 64'd0);
        chk("i_imm64", immext64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i_tgt64", tgt64, 64'h0000_0000_0000_00FF);

        send1(32'hFE000EE3, IMM_B, 32'h100);
        chk("b_imm", immext32, 64'hFFFF_FFFC);
        chk("b_tgt", tgt32, 64'h0000_00FC);

        send1(32'h001000EF, IMM_J, 32'h1000);
        chk("j_imm", immext32, 64'h0000_0800);
        chk("j_tgt", tgt32, 64'h0000_1800);

        send1(32'h123450B7, IMM_U, 32'h0);
        chk("u_imm", immext32, 64'h1234_5000);

        send1(32'h000F8073, IMM_Z, 32'h40);
        chk("z_imm", immext32, 64'h0000_001F);

        send1(32'h12345678, IMM_RSV, 32'h444);
        chk("rsv_imm", immext32, 64'd0);
        chk("rsv_ill", illegal32, 64'd1);
        chk("rsv_tgt", tgt32, 64'h444);

        send1(32'h00800093, IMM_I, 32'hFFFF_FFFC);
        chk("wrap_tgt", tgt32, 64'h0000_0004);
        chk("wrap_tgt64", tgt64, 64'h0000_0001_0000_0004);

        send1(32'h800000B7, IMM_U, 32'h0);
        chk("u64_imm", immext64, 64'hFFFF_FFFF_8000_0000);
        chk("u32_imm", immext32, 64'h8000_0000);

        send1(32'h03F00013, IMM_SH, 32'h0);
        chk("sh64_imm", immext64, 64'h0000_0000_0000_003F);
        chk("sh32_imm", immext32, 64'h0000_001F);

        // Backpressure: three beats with out_ready low.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; immsrc = IMM_I; pc32 = 32'h200; pc64 = 64'h200;
        instr = 32'h00100093;
        chk("bp_ready0", in_ready32, 64'd1);
        @(negedge clk);
        chk("bp_ready1", in_ready32, 64'd1);
        chk("bp_head1", immext32, 64'd1);
        instr = 32'h00200093;
        @(negedge clk);
        chk("bp_ready2", in_ready32, 64'd0);
        chk("bp_ready2_64", in_ready64, 64'd0);
        chk("bp_head2", immext32, 64'd1);
        instr = 32'h00300093;
        @(negedge clk);
        chk("bp_held", in_ready32, 64'd0);
        chk("bp_head3", immext32, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_recover", in_ready32, 64'd1);
        chk("bp_second", immext32, 64'd2);
        chk("bp_second_tgt", tgt32, 64'h202);
        @(negedge clk);
        chk("bp_third", immext32, 64'd3);
        chk("bp_third_valid", out_valid32, 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid32, 64'd0);

        // Flush from TWO with a concurrent beat that must be dropped.
        fill_two();
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00D00093;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid", out_valid32, 64'd0);
        chk("fl_in_ready", in_ready32, 64'd1);
        chk("fl_out_valid64", out_valid64, 64'd0);
        @(negedge clk);
        chk("fl_dropped", out_valid32, 64'd0);

        // Asynchronous reset mid-cycle while full.
        fill_two();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_in_ready", in_ready32, 64'd1);
        chk("ar_out_valid", out_valid32, 64'd0);
        chk("ar_immext", immext32, 64'd0);
        chk("ar_target", tgt32, 64'd0);
        chk("ar_illegal", illegal32, 64'd0);
        chk("ar_immext64", immext64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("ar_discarded", out_valid32, 64'd0);

        // Randomized traffic against the queue model (buffers are empty here).
        for (int c = 0; c < 500; c++) begin
            logic push_b;
            logic pop_b;
            check_models();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = $urandom;
            immsrc    = 3'($urandom_range(0, 7));
            pc32      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom);
            pc64      = {32'($urandom), pc32};
            push_b = in_valid && (q32.size() < 2);
            pop_b  = (q32.size() != 0) && out_ready;
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (pop_b) begin
                    void'(q32.pop_front());
                    void'(q64.pop_front());
                end
                if (push_b) begin
                    q32.push_back(ref_beat(instr, immsrc, {32'h0, pc32}, 32));
                    q64.push_back(ref_beat(instr, immsrc, pc64, 64));
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0;
        check_models();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
